bus_transfer_arbiter: RTL and testbench

Arbitrates the shared 32-bit datapath bus among several transfer requesters (control unit, I/O port logic, debug/load port) and sequences each granted register-to-register transfer. It drives the bus multiplexer's one-hot source out-enables and the destination registers' one-hot load enables, so that no two sources ever drive the bus at once. It sits between the requesters and the bus mux / register file.

---
 rtl/bus_transfer_arbiter_pkg.sv | 46 ++++
 rtl/bus_transfer_arbiter_if.sv | 29 ++
 rtl/bus_transfer_arbiter_onehot_decoder.sv | 17 +
 rtl/bus_transfer_arbiter.sv | 147 ++++++++++++++
 tb/tb_bus_transfer_arbiter.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bus_transfer_arbiter_pkg.sv
// Shared definitions for the datapath bus arbiter: code widths, named bus
// source/destination codes and the transfer sequencer state type.
package bus_pkg;

  localparam int SEL_W = 5;
  localparam int NSRC  = 24;
  localparam int NDST  = 24;

  localparam int SRC_R0  = 0;  localparam int SRC_R1  = 1;  localparam int SRC_R2  = 2;
  localparam int SRC_R3  = 3;  localparam int SRC_R4  = 4;  localparam int SRC_R5  = 5;
  localparam int SRC_R6  = 6;  localparam int SRC_R7  = 7;  localparam int SRC_R8  = 8;
  localparam int SRC_R9  = 9;  localparam int SRC_R10 = 10; localparam int SRC_R11 = 11;
  localparam int SRC_R12 = 12; localparam int SRC_R13 = 13; localparam int SRC_R14 = 14;
  localparam int SRC_R15 = 15;
  localparam int SRC_HI     = 16;
  localparam int SRC_LO     = 17;
  localparam int SRC_ZHIGH  = 18;
  localparam int SRC_ZLOW   = 19;
  localparam int SRC_PC     = 20;
  localparam int SRC_MDR    = 21;
  localparam int SRC_INPORT = 22;
  localparam int SRC_CSIGN  = 23;

  localparam int DST_R0  = 0;  localparam int DST_R1  = 1;  localparam int DST_R2  = 2;
  localparam int DST_R3  = 3;  localparam int DST_R4  = 4;  localparam int DST_R5  = 5;
  localparam int DST_R6  = 6;  localparam int DST_R7  = 7;  localparam int DST_R8  = 8;
  localparam int DST_R9  = 9;  localparam int DST_R10 = 10; localparam int DST_R11 = 11;
  localparam int DST_R12 = 12; localparam int DST_R13 = 13; localparam int DST_R14 = 14;
  localparam int DST_R15 = 15;
  localparam int DST_HI      = 16;
  localparam int DST_LO      = 17;
  localparam int DST_PC      = 18;
  localparam int DST_MDR     = 19;
  localparam int DST_MAR     = 20;
  localparam int DST_IR      = 21;
  localparam int DST_Y       = 22;
  localparam int DST_OUTPORT = 23;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_LOAD  = 2'd2,
    ST_ERR   = 2'd3
  } state_t;

endpackage

// File: rtl/bus_transfer_arbiter_if.sv
// Requester/bus-control bundle between the transfer requesters and the
// arbiter; master = requester side, slave = arbiter side.
interface bus_transfer_arbiter_if #(
  parameter int NREQ  = 3,
  parameter int SEL_W = bus_pkg::SEL_W,
  parameter int NSRC  = bus_pkg::NSRC,
  parameter int NDST  = bus_pkg::NDST
) ();

  logic [NREQ-1:0]       req;
  logic [NREQ*SEL_W-1:0] src_sel;
  logic [NREQ*SEL_W-1:0] dst_sel;
  logic [NREQ-1:0]       done;
  logic [NSRC-1:0]       bus_out_en;
  logic [NDST-1:0]       reg_in_en;
  logic                  busy;
  logic                  err;

  modport master (
    output req, src_sel, dst_sel,
    input  done, bus_out_en, reg_in_en, busy, err
  );

  modport slave (
    input  req, src_sel, dst_sel,
    output done, bus_out_en, reg_in_en, busy, err
  );

endinterface

// File: rtl/bus_transfer_arbiter_onehot_decoder.sv
// Code to one-hot enable decoder; codes at or above WIDTH give all zeros.
module onehot_decoder #(
  parameter int WIDTH = 24,
  parameter int SEL_W = 5
) (
  input  logic [SEL_W-1:0] code,
  output logic [WIDTH-1:0] onehot
);

  always_comb begin
    onehot = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (32'(code) == i) onehot[i] = 1'b1;
    end
  end

endmodule

// File: rtl/bus_transfer_arbiter.sv
// Round-robin arbiter and DRIVE/LOAD sequencer for the shared datapath bus.
// Optional invalid-code trap enabled by defining BUS_ARB_ERR_EN.
module bus_transfer_arbiter #(
  parameter int NREQ  = 3,
  parameter int SEL_W = bus_pkg::SEL_W,
  parameter int NSRC  = bus_pkg::NSRC,
  parameter int NDST  = bus_pkg::NDST
) (
  input logic                  clock,
  input logic                  clear,
  bus_transfer_arbiter_if.slave bus
);

  import bus_pkg::*;

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NREQ - 1);

  state_t           state;
  logic [IDX_W-1:0] last_winner;
  logic [IDX_W-1:0] winner;
  logic [IDX_W-1:0] grant_idx;
  logic [IDX_W-1:0] cand;
  logic             any_req;
  logic [SEL_W-1:0] grant_src;
  logic [SEL_W-1:0] grant_dst;
  logic [SEL_W-1:0] dst_q;
  logic [NSRC-1:0]  src_onehot;
  logic [NDST-1:0]  dst_onehot;
  logic [NSRC-1:0]  bus_out_en_q;
  logic [NDST-1:0]  reg_in_en_q;
  logic [NREQ-1:0]  done_q;
  logic             busy_q;

  // Scan starts just after the last winner so every requester gets a turn.
  always_comb begin
    any_req   = 1'b0;
    grant_idx = last_winner;
    cand      = '0;
    for (int unsigned off = 1; off <= NREQ; off++) begin
      cand = IDX_W'((32'(last_winner) + off) % NREQ);
      if (!any_req && bus.req[cand]) begin
        any_req   = 1'b1;
        grant_idx = cand;
      end
    end
  end

  always_comb begin
    grant_src = '0;
    grant_dst = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant_idx == IDX_W'(i)) begin
        grant_src = bus.src_sel[i*SEL_W +: SEL_W];
        grant_dst = bus.dst_sel[i*SEL_W +: SEL_W];
      end
    end
  end

  onehot_decoder #(.WIDTH(NSRC), .SEL_W(SEL_W)) u_src_dec (
    .code   (grant_src),
    .onehot (src_onehot)
  );

  onehot_decoder #(.WIDTH(NDST), .SEL_W(SEL_W)) u_dst_dec (
    .code   (dst_q),
    .onehot (dst_onehot)
  );

`ifdef BUS_ARB_ERR_EN
  logic code_bad;
  logic err_q;
  assign code_bad = (32'(grant_src) >= NSRC) || (32'(grant_dst) >= NDST);
  assign bus.err  = err_q;
`else
  assign bus.err  = 1'b0;
`endif

  // The source code is held in decoded form: bus_out_en_q is loaded at grant
  // and kept through LOAD, so later src_sel changes cannot reach the bus.
  always_ff @(posedge clock) begin
    if (clear) begin
      state        <= ST_IDLE;
      last_winner  <= LAST_RST;
      winner       <= '0;
      dst_q        <= '0;
      bus_out_en_q <= '0;
      reg_in_en_q  <= '0;
      done_q       <= '0;
      busy_q       <= 1'b0;
`ifdef BUS_ARB_ERR_EN
      err_q        <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            winner       <= grant_idx;
            dst_q        <= grant_dst;
            busy_q       <= 1'b1;
            bus_out_en_q <= src_onehot;
            state        <= ST_DRIVE;
`ifdef BUS_ARB_ERR_EN
            if (code_bad) begin
              bus_out_en_q        <= '0;
              done_q[grant_idx]   <= 1'b1;
              err_q               <= 1'b1;
              state               <= ST_ERR;
            end
`endif
          end
        end
        ST_DRIVE: begin
          reg_in_en_q    <= dst_onehot;
          done_q[winner] <= 1'b1;
          state          <= ST_LOAD;
        end
`ifdef BUS_ARB_ERR_EN
        ST_LOAD, ST_ERR: begin
          err_q        <= 1'b0;
`else
        ST_LOAD: begin
`endif
          bus_out_en_q <= '0;
          reg_in_en_q  <= '0;
          done_q       <= '0;
          busy_q       <= 1'b0;
          last_winner  <= winner;
          state        <= ST_IDLE;
        end
        default: begin
          bus_out_en_q <= '0;
          reg_in_en_q  <= '0;
          done_q       <= '0;
          busy_q       <= 1'b0;
          state        <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.bus_out_en = bus_out_en_q;
  assign bus.reg_in_en  = reg_in_en_q;
  assign bus.done       = done_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_bus_transfer_arbiter.sv
// Self-checking bench for bus_transfer_arbiter against a transaction-level
// round-robin model; expectations follow BUS_ARB_ERR_EN when it is defined.
module tb_bus_transfer_arbiter;

  import bus_pkg::*;

  localparam int NR = 3;
  localparam int SW = 5;
  localparam int NS = 24;
  localparam int ND = 24;

  logic clock = 1'b0;
  logic clear = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   m_last;

  bus_transfer_arbiter_if #(.NREQ(NR), .SEL_W(SW), .NSRC(NS), .NDST(ND)) bus_if ();

  bus_transfer_arbiter #(.NREQ(NR), .SEL_W(SW), .NSRC(NS), .NDST(ND)) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus_if)
  );

  always #5 clock = ~clock;

  function automatic logic [23:0] exp_oh(input int code, input int n);
    logic [23:0] v;
    v = '0;
    if (code >= 0 && code < n) v = 24'(1) << code;
    return v;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_codes(input int r, input int s, input int d);
    bus_if.src_sel[r*SW +: SW] = SW'(s);
    bus_if.dst_sel[r*SW +: SW] = SW'(d);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    bus_if.req = '0;
    step();
    step();
    clear = 1'b0;
    m_last = NR - 1;
  endtask

  task automatic test_reset();
    bus_if.req = '0; bus_if.src_sel = '0; bus_if.dst_sel = '0;
    do_clear();
    checks++;
    if ({bus_if.bus_out_en, bus_if.reg_in_en, bus_if.done, bus_if.busy, bus_if.err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got bus=%h reg=%h done=%b busy=%b err=%b, want all 0",
               bus_if.bus_out_en, bus_if.reg_in_en, bus_if.done, bus_if.busy, bus_if.err);
    end
  endtask

  task automatic test_single();
    do_clear();
    set_codes(0, SRC_PC, DST_MAR);
    bus_if.req = 3'b001;
    step();
    checks++;
    if (bus_if.bus_out_en !== exp_oh(SRC_PC, NS) || bus_if.reg_in_en !== '0 ||
        bus_if.done !== '0 || bus_if.busy !== 1'b1) begin
      errors++;
      $display("FAIL single_drive: got bus=%h reg=%h done=%b busy=%b, want bus=%h reg=0 done=000 busy=1",
               bus_if.bus_out_en, bus_if.reg_in_en, bus_if.done, bus_if.busy, exp_oh(SRC_PC, NS));
    end
    step();
    checks++;
    if (bus_if.bus_out_en !== exp_oh(SRC_PC, NS) || bus_if.reg_in_en !== exp_oh(DST_MAR, ND) ||
        bus_if.done !== 3'b001) begin
      errors++;
      $display("FAIL single_load: got bus=%h reg=%h done=%b, want bus=%h reg=%h done=001",
               bus_if.bus_out_en, bus_if.reg_in_en, bus_if.done,
               exp_oh(SRC_PC, NS), exp_oh(DST_MAR, ND));
    end
    step();
    bus_if.req = '0;
    checks++;
    if ({bus_if.bus_out_en, bus_if.reg_in_en, bus_if.done, bus_if.busy} !== '0) begin
      errors++;
      $display("FAIL single_after: got bus=%h reg=%h done=%b busy=%b, want all 0",
               bus_if.bus_out_en, bus_if.reg_in_en, bus_if.done, bus_if.busy);
    end
  endtask

  task automatic test_round_robin();
    logic [2:0] want;
    int pulses;
    do_clear();
    for (int r = 0; r < NR; r++) set_codes(r, r + 1, r + 4);
    bus_if.req = 3'b111;
    pulses = 0;
    for (int c = 1; c <= 12; c++) begin
      step();
      // Winner r is served in slot r; LOAD is the second cycle after its grant.
      want = ((c % 3) == 2) ? 3'(1 << (pulses % NR)) : 3'b000;
      checks++;
      if (bus_if.done !== want || $countones(bus_if.bus_out_en) > 1) begin
        errors++;
        $display("FAIL rr_done_c%0d: got done=%b bus=%h, want done=%b and at most one-hot bus",
                 c, bus_if.done, bus_if.bus_out_en, want);
      end
      if (want != 3'b000) pulses++;
    end
    bus_if.req = '0;
    step();
  endtask

  task automatic test_mid_reset();
    do_clear();
    set_codes(0, SRC_MDR, DST_IR);
    set_codes(1, SRC_HI, DST_Y);
    bus_if.req = 3'b010;
    step();
    checks++;
    if (bus_if.bus_out_en !== exp_oh(SRC_HI, NS)) begin
      errors++;
      $display("FAIL midrst_drive: got bus=%h, want %h", bus_if.bus_out_en, exp_oh(SRC_HI, NS));
    end
    clear = 1'b1;
    step();
    clear = 1'b0;
    bus_if.req = 3'b011;
    checks++;
    if ({bus_if.bus_out_en, bus_if.reg_in_en, bus_if.done, bus_if.busy, bus_if.err} !== '0) begin
      errors++;
      $display("FAIL midrst_abort: got bus=%h reg=%h done=%b busy=%b, want all 0",
               bus_if.bus_out_en, bus_if.reg_in_en, bus_if.done, bus_if.busy);
    end
    step();
    checks++;
    if (bus_if.bus_out_en !== exp_oh(SRC_MDR, NS)) begin
      errors++;
      $display("FAIL midrst_regrant: got bus=%h, want %h (requester 0)",
               bus_if.bus_out_en, exp_oh(SRC_MDR, NS));
    end
    step();
    checks++;
    if (bus_if.done !== 3'b001 || bus_if.reg_in_en !== exp_oh(DST_IR, ND)) begin
      errors++;
      $display("FAIL midrst_load: got done=%b reg=%h, want done=001 reg=%h",
               bus_if.done, bus_if.reg_in_en, exp_oh(DST_IR, ND));
    end
    step();
    bus_if.req = '0;
    step();
  endtask

  task automatic test_code_latch();
    do_clear();
    set_codes(2, 5, 9);
    bus_if.req = 3'b100;
    step();
    set_codes(2, 7, 11);
    step();
    checks++;
    if (bus_if.bus_out_en !== exp_oh(5, NS) || bus_if.reg_in_en !== exp_oh(9, ND) ||
        bus_if.done !== 3'b100) begin
      errors++;
      $display("FAIL latch_load: got bus=%h reg=%h done=%b, want bus=%h reg=%h done=100",
               bus_if.bus_out_en, bus_if.reg_in_en, bus_if.done, exp_oh(5, NS), exp_oh(9, ND));
    end
    step();
    bus_if.req = '0;
  endtask

  task automatic test_invalid();
    int cs[2];
    int cd[2];
    cs[0] = 25; cd[0] = 3;
    cs[1] = 2;  cd[1] = 30;
    for (int k = 0; k < 2; k++) begin
      do_clear();
      set_codes(2, cs[k], cd[k]);
      bus_if.req = 3'b100;
      step();
`ifdef BUS_ARB_ERR_EN
      checks++;
      if (bus_if.err !== 1'b1 || bus_if.done !== 3'b100 || bus_if.bus_out_en !== '0 ||
          bus_if.reg_in_en !== '0 || bus_if.busy !== 1'b1) begin
        errors++;
        $display("FAIL invalid_err_%0d: got err=%b done=%b bus=%h reg=%h busy=%b, want err=1 done=100 no enables",
                 k, bus_if.err, bus_if.done, bus_if.bus_out_en, bus_if.reg_in_en, bus_if.busy);
      end
`else
      checks++;
      if (bus_if.bus_out_en !== exp_oh(cs[k], NS) || bus_if.done !== '0 || bus_if.err !== 1'b0) begin
        errors++;
        $display("FAIL invalid_drive_%0d: got bus=%h done=%b err=%b, want bus=%h done=000 err=0",
                 k, bus_if.bus_out_en, bus_if.done, bus_if.err, exp_oh(cs[k], NS));
      end
      step();
      checks++;
      if (bus_if.bus_out_en !== exp_oh(cs[k], NS) || bus_if.reg_in_en !== exp_oh(cd[k], ND) ||
          bus_if.done !== 3'b100 || bus_if.err !== 1'b0) begin
        errors++;
        $display("FAIL invalid_load_%0d: got bus=%h reg=%h done=%b err=%b, want bus=%h reg=%h done=100 err=0",
                 k, bus_if.bus_out_en, bus_if.reg_in_en, bus_if.done, bus_if.err,
                 exp_oh(cs[k], NS), exp_oh(cd[k], ND));
      end
`endif
      step();
      bus_if.req = '0;
      checks++;
      if ({bus_if.bus_out_en, bus_if.reg_in_en, bus_if.done, bus_if.busy, bus_if.err} !== '0) begin
        errors++;
        $display("FAIL invalid_after_%0d: got bus=%h reg=%h done=%b busy=%b err=%b, want all 0",
                 k, bus_if.bus_out_en, bus_if.reg_in_en, bus_if.done, bus_if.busy, bus_if.err);
      end
    end
  endtask

  task automatic test_random();
    logic [2:0] reqv;
    int src[NR];
    int dst[NR];
    int w;
    int idx;
    do_clear();
    reqv = '0;
    for (int t = 0; t < 40; t++) begin
      reqv = reqv | 3'($urandom_range(0, 7));
      for (int r = 0; r < NR; r++) begin
        src[r] = $urandom_range(0, NS - 1);
        dst[r] = $urandom_range(0, ND - 1);
        set_codes(r, src[r], dst[r]);
      end
      bus_if.req = reqv;
      if (reqv == 3'b000) begin
        step();
        checks++;
        if (bus_if.busy !== 1'b0 || bus_if.bus_out_en !== '0) begin
          errors++;
          $display("FAIL rand_idle_t%0d: got busy=%b bus=%h, want idle", t, bus_if.busy, bus_if.bus_out_en);
        end
        continue;
      end
      w = -1;
      for (int k = 1; k <= NR; k++) begin
        idx = (m_last + k) % NR;
        if (w < 0 && reqv[idx]) w = idx;
      end
      step();
      checks++;
      if (bus_if.bus_out_en !== exp_oh(src[w], NS) || bus_if.reg_in_en !== '0 ||
          bus_if.done !== '0 || bus_if.busy !== 1'b1 || bus_if.err !== 1'b0) begin
        errors++;
        $display("FAIL rand_drive_t%0d: got bus=%h reg=%h done=%b busy=%b, want bus=%h winner=%0d",
                 t, bus_if.bus_out_en, bus_if.reg_in_en, bus_if.done, bus_if.busy, exp_oh(src[w], NS), w);
      end
      for (int r = 0; r < NR; r++) set_codes(r, $urandom_range(0, 31), $urandom_range(0, 31));
      step();
      checks++;
      if (bus_if.bus_out_en !== exp_oh(src[w], NS) || bus_if.reg_in_en !== exp_oh(dst[w], ND) ||
          bus_if.done !== 3'(1 << w)) begin
        errors++;
        $display("FAIL rand_load_t%0d: got bus=%h reg=%h done=%b, want bus=%h reg=%h done=%b",
                 t, bus_if.bus_out_en, bus_if.reg_in_en, bus_if.done,
                 exp_oh(src[w], NS), exp_oh(dst[w], ND), 3'(1 << w));
      end
      step();
      reqv[w] = 1'b0;
      m_last  = w;
      bus_if.req = reqv;
      checks++;
      if ({bus_if.bus_out_en, bus_if.reg_in_en, bus_if.done, bus_if.busy} !== '0) begin
        errors++;
        $display("FAIL rand_after_t%0d: got bus=%h reg=%h done=%b busy=%b, want all 0",
                 t, bus_if.bus_out_en, bus_if.reg_in_en, bus_if.done, bus_if.busy);
      end
    end
    bus_if.req = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_mid_reset();
    test_code_latch();
    test_invalid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
